// File: rtl/concat_n_requant_pkg.sv
// concat_pkg: shared types, default widths and the output saturation helper
// for the concat_n_requant block.
//   state_t  : sequencing FSM encoding
//   *_DEF    : default parameter values for the top and the lane datapath
//   sat_u8() : clamp a signed intermediate result to an unsigned byte
package concat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int NUM_IN_DEF  = 2;
  localparam int LANES_DEF   = 8;
  localparam int PIX_W_DEF   = 20;
  localparam int GRP_W_DEF   = 10;
  localparam int SCALE_W_DEF = 16;
  localparam int SHIFT_DEF   = 15;

  function automatic logic [7:0] sat_u8(input logic signed [31:0] v);
    if (v < 0) return 8'd0;
    if (v > 32'sd255) return 8'd255;
    return v[7:0];
  endfunction

endpackage

// File: rtl/concat_n_requant_lane.sv
// concat_requant_lane: one 8-bit requantisation lane, two registered stages.
//   s1: (x - zp_in) * scale            -> p_q
//   s2: round, arithmetic shift, + zp_out, saturate to [0,255] -> y_o
// Ports:
//   clk, rst       clock, async active-high reset
//   en_i           global pipeline enable (low = stall, both stages hold)
//   x_i, zp_in_i   input byte and its zero point
//   scale_i        unsigned fixed-point scale of the source input
//   zp_out_i       common output zero point
//   y_o            requantised byte, two enabled cycles after x_i
module concat_requant_lane
  import concat_pkg::*;
#(
  parameter int SCALE_W = SCALE_W_DEF,
  parameter int SHIFT   = SHIFT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic [7:0]         x_i,
  input  logic [7:0]         zp_in_i,
  input  logic [SCALE_W-1:0] scale_i,
  input  logic [7:0]         zp_out_i,
  output logic [7:0]         y_o
);

  localparam int P_W = 9 + SCALE_W + 1;
  localparam logic signed [31:0] RND = 32'sd1 <<< (SHIFT - 1);

  logic signed [8:0]     diff;
  logic signed [P_W-1:0] diff_ext, scale_ext, p_d, p_q;
  logic signed [31:0]    p_wide, r_wide, y_wide;
  logic [7:0]            y_d, y_q;

  always_comb begin
    diff      = $signed({1'b0, x_i}) - $signed({1'b0, zp_in_i});
    diff_ext  = {{(P_W-9){diff[8]}}, diff};
    scale_ext = {{(P_W-SCALE_W){1'b0}}, scale_i};
    p_d       = diff_ext * scale_ext;
  end

  // Round half up, then floor via arithmetic shift (negative values round toward -inf).
  always_comb begin
    p_wide = {{(32-P_W){p_q[P_W-1]}}, p_q};
    r_wide = (p_wide + RND) >>> SHIFT;
    y_wide = r_wide + $signed({24'd0, zp_out_i});
    y_d    = sat_u8(y_wide);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q <= '0;
      y_q <= '0;
    end else if (en_i) begin
      p_q <= p_d;
      y_q <= y_d;
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/concat_n_requant.sv
// concat_n_requant: channel-wise concatenation of NUM_IN activation streams
// with per-input requantisation into a common output quantisation.
// Per pixel, Group_Num[i] beats are taken from each input i in order
// (zero-group inputs skipped); each beat passes a 2-stage lane pipeline.
// Ports:
//   clk, rst                     clock, async active-high reset
//   Start                        pulse, latches all Cfg_* while idle
//   Cfg_*                        frame configuration (packed per input)
//   S_Data/S_Valid/S_Ready       per-input beat streams
//   M_Data/M_Valid/M_Ready       concatenated, requantised output stream
//   Last_Concat                  marks the final output beat of the frame
//   Busy, Done                   frame in progress / one-cycle completion pulse
//
// state    | meaning
// ST_IDLE  | waiting for Start
// ST_RUN   | accepting input beats in sel/grp/pix order
// ST_DRAIN | all inputs consumed, waiting for the Last beat to leave M
// ST_DONE  | Done pulse, back to idle next cycle
module concat_n_requant
  import concat_pkg::*;
#(
  parameter int NUM_IN  = NUM_IN_DEF,
  parameter int LANES   = LANES_DEF,
  parameter int PIX_W   = PIX_W_DEF,
  parameter int GRP_W   = GRP_W_DEF,
  parameter int SCALE_W = SCALE_W_DEF,
  parameter int SHIFT   = SHIFT_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        Start,
  input  logic [PIX_W-1:0]            Cfg_Pixel_Num,
  input  logic [NUM_IN*GRP_W-1:0]     Cfg_Group_Num,
  input  logic [NUM_IN*8-1:0]         Cfg_ZeroPoint_In,
  input  logic [NUM_IN*SCALE_W-1:0]   Cfg_Scale,
  input  logic [7:0]                  Cfg_ZeroPoint_Out,
  input  logic [NUM_IN*LANES*8-1:0]   S_Data,
  input  logic [NUM_IN-1:0]           S_Valid,
  output logic [NUM_IN-1:0]           S_Ready,
  output logic [LANES*8-1:0]          M_Data,
  output logic                        M_Valid,
  input  logic                        M_Ready,
  output logic                        Last_Concat,
  output logic                        Busy,
  output logic                        Done
);

  localparam int DATA_W = LANES * 8;
  localparam int SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [GRP_W-1:0]   grp_q, grp_d;
  logic [PIX_W-1:0]   pix_q, pix_d;

  logic [PIX_W-1:0]   pix_num_q;
  logic [GRP_W-1:0]   grp_num_q [NUM_IN];
  logic [7:0]         zp_in_q   [NUM_IN];
  logic [SCALE_W-1:0] scale_q   [NUM_IN];
  logic [7:0]         zp_out_q;

  logic v1_q, v2_q, l1_q, l2_q;
  logic run, pipe_en, accept, grp_last, pix_last, last_beat, load;
  logic nxt_found, start_found;
  logic [SEL_W-1:0]   nxt_sel, first_sel, start_sel;
  logic [DATA_W-1:0]  x_mux;
  logic [7:0]         zp_mux;
  logic [SCALE_W-1:0] scale_mux;

  // Descending scans so the lowest qualifying index wins.
  always_comb begin
    nxt_found   = 1'b0;
    nxt_sel     = '0;
    first_sel   = '0;
    start_found = 1'b0;
    start_sel   = '0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (grp_num_q[i] != '0) first_sel = SEL_W'(i);
      if (grp_num_q[i] != '0 && SEL_W'(i) > sel_q) begin
        nxt_found = 1'b1;
        nxt_sel   = SEL_W'(i);
      end
      if (Cfg_Group_Num[i*GRP_W +: GRP_W] != '0) begin
        start_found = 1'b1;
        start_sel   = SEL_W'(i);
      end
    end
  end

  assign run       = (state_q == ST_RUN);
  assign pipe_en   = !(v2_q && !M_Ready);
  assign accept    = run && pipe_en && S_Valid[sel_q];
  assign grp_last  = (grp_q == grp_num_q[sel_q] - GRP_W'(1));
  assign pix_last  = (pix_q == pix_num_q - PIX_W'(1));
  assign last_beat = grp_last && !nxt_found && pix_last;
  assign load      = (state_q == ST_IDLE) && Start;

  always_comb begin
    S_Ready = '0;
    for (int i = 0; i < NUM_IN; i++) S_Ready[i] = run && pipe_en && (sel_q == SEL_W'(i));
  end

  assign x_mux     = S_Data[sel_q*DATA_W +: DATA_W];
  assign zp_mux    = zp_in_q[sel_q];
  assign scale_mux = scale_q[sel_q];

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    grp_d   = grp_q;
    pix_d   = pix_q;
    case (state_q)
      ST_IDLE: if (Start) begin
        sel_d   = start_sel;
        grp_d   = '0;
        pix_d   = '0;
        state_d = (Cfg_Pixel_Num == '0 || !start_found) ? ST_DONE : ST_RUN;
      end
      ST_RUN: if (accept) begin
        if (grp_last) begin
          grp_d = '0;
          if (nxt_found) begin
            sel_d = nxt_sel;
          end else begin
            sel_d = first_sel;
            pix_d = pix_q + PIX_W'(1);
            if (pix_last) state_d = ST_DRAIN;
          end
        end else begin
          grp_d = grp_q + GRP_W'(1);
        end
      end
      ST_DRAIN: if (v2_q && M_Ready && l2_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      grp_q   <= '0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      grp_q   <= grp_d;
      pix_q   <= pix_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_num_q <= '0;
      zp_out_q  <= '0;
      for (int i = 0; i < NUM_IN; i++) begin
        grp_num_q[i] <= '0;
        zp_in_q[i]   <= '0;
        scale_q[i]   <= '0;
      end
    end else if (load) begin
      pix_num_q <= Cfg_Pixel_Num;
      zp_out_q  <= Cfg_ZeroPoint_Out;
      for (int i = 0; i < NUM_IN; i++) begin
        grp_num_q[i] <= Cfg_Group_Num[i*GRP_W +: GRP_W];
        zp_in_q[i]   <= Cfg_ZeroPoint_In[i*8 +: 8];
        scale_q[i]   <= Cfg_Scale[i*SCALE_W +: SCALE_W];
      end
    end
  end

  // Valid/last ride alongside the lane datapath under the same global stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      l1_q <= 1'b0;
      l2_q <= 1'b0;
    end else if (pipe_en) begin
      v1_q <= accept;
      l1_q <= accept && last_beat;
      v2_q <= v1_q;
      l2_q <= l1_q;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    concat_requant_lane #(
      .SCALE_W (SCALE_W),
      .SHIFT   (SHIFT)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .en_i     (pipe_en),
      .x_i      (x_mux[l*8 +: 8]),
      .zp_in_i  (zp_mux),
      .scale_i  (scale_mux),
      .zp_out_i (zp_out_q),
      .y_o      (M_Data[l*8 +: 8])
    );
  end

  assign M_Valid     = v2_q;
  assign Last_Concat = l2_q;
  assign Busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign Done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_concat_n_requant.sv
// Scoreboard bench for concat_n_requant (NUM_IN=3, LANES=8, SHIFT=15).
module tb_concat_n_requant;

  localparam int NI = 3, LANES = 8, DW = 64, PIX_W = 20, GRP_W = 10, SCALE_W = 16, SHIFT = 15;

  logic                  clk = 1'b0;
  logic                  rst, Start;
  logic [PIX_W-1:0]      Cfg_Pixel_Num;
  logic [NI*GRP_W-1:0]   Cfg_Group_Num;
  logic [NI*8-1:0]       Cfg_ZeroPoint_In;
  logic [NI*SCALE_W-1:0] Cfg_Scale;
  logic [7:0]            Cfg_ZeroPoint_Out;
  logic [NI*DW-1:0]      S_Data;
  logic [NI-1:0]         S_Valid, S_Ready, drv_valid, bg_valid;
  logic [DW-1:0]         M_Data;
  logic                  M_Valid, M_Ready, Last_Concat, Busy, Done;

  assign S_Valid = drv_valid | bg_valid;

  concat_n_requant #(
    .NUM_IN(NI), .LANES(LANES), .PIX_W(PIX_W), .GRP_W(GRP_W), .SCALE_W(SCALE_W), .SHIFT(SHIFT)
  ) dut (
    .clk(clk), .rst(rst), .Start(Start),
    .Cfg_Pixel_Num(Cfg_Pixel_Num), .Cfg_Group_Num(Cfg_Group_Num),
    .Cfg_ZeroPoint_In(Cfg_ZeroPoint_In), .Cfg_Scale(Cfg_Scale), .Cfg_ZeroPoint_Out(Cfg_ZeroPoint_Out),
    .S_Data(S_Data), .S_Valid(S_Valid), .S_Ready(S_Ready),
    .M_Data(M_Data), .M_Valid(M_Valid), .M_Ready(M_Ready),
    .Last_Concat(Last_Concat), .Busy(Busy), .Done(Done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0, n_bad = 0, cyc = 0;
  int          grp[NI], zpi[NI], scl[NI], zpo, pixn;
  logic [63:0] fixed_data[NI], hand_exp[NI];
  bit          rnd_ready = 0, abort = 0, watch_other = 0;
  int          first_acc, first_out, last_out, last_acc, n_out;
  bit          other_seen, mv_seen, held_valid;
  logic [63:0] held_data;
  logic        held_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model(input int x, input int zp, input int scale, input int zo);
    longint d, p, num, r, y;
    d = x - zp;
    p = d * scale;
    num = p + 16384;
    if (num >= 0) r = num / 32768;
    else r = -((-num + 32767) / 32768);
    y = r + zo;
    if (y < 0) y = 0;
    if (y > 255) y = 255;
    return 8'(y);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    M_Ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      M_Ready = rnd_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every M handshake and checks stall stability.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_valid = 0;
      end else begin
        if (watch_other && (S_Ready[0] || S_Ready[2])) other_seen = 1;
        if (M_Valid) begin
          mv_seen = 1;
          if (first_out < 0) first_out = cyc;
          last_out = cyc;
          if (held_valid) begin
            check("hold_data", M_Data, held_data);
            check("hold_last", 64'(Last_Concat), 64'(held_last));
          end
          if (M_Ready) begin
            held_valid = 0;
            n_out++;
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_beat: got %0h with no expected beat queued", M_Data);
            end else begin
              e = exp_q.pop_front();
              check("beat_data", M_Data, e.data);
              check("beat_last", 64'(Last_Concat), 64'(e.last));
            end
            if (Last_Concat) last_acc = cyc;
          end else begin
            held_valid = 1;
            held_data  = M_Data;
            held_last  = Last_Concat;
          end
        end else if (held_valid) begin
          n_cmp++;
          n_bad++;
          $display("FAIL hold_valid: got M_Valid=0 during stall, required 1");
          held_valid = 0;
        end
      end
    end
  end

  task automatic apply_cfg();
    for (int i = 0; i < NI; i++) begin
      Cfg_Group_Num[i*GRP_W +: GRP_W]   = GRP_W'(grp[i]);
      Cfg_ZeroPoint_In[i*8 +: 8]        = 8'(zpi[i]);
      Cfg_Scale[i*SCALE_W +: SCALE_W]   = SCALE_W'(scl[i]);
    end
    Cfg_Pixel_Num     = PIX_W'(pixn);
    Cfg_ZeroPoint_Out = 8'(zpo);
  endtask

  task automatic reset_trackers();
    first_acc = -1; first_out = -1; last_out = -1; last_acc = -1;
    n_out = 0; other_seen = 0; mv_seen = 0;
  endtask

  task automatic start_pulse(output int scyc);
    Start = 1'b1;
    @(negedge clk);
    scyc = cyc;
    @(posedge clk);
    #1;
    Start = 1'b0;
  endtask

  // mode 0: identity pattern, 1: random data vs model, 2: fixed data vs hand values
  task automatic drive_frame(input int mode, input bit rnd);
    int          last_in, n;
    bit          acc;
    logic [63:0] d;
    exp_t        ex;
    last_in = -1;
    for (int i = 0; i < NI; i++) if (grp[i] > 0) last_in = i;
    for (int p = 0; p < pixn; p++) begin
      for (int i = 0; i < NI; i++) begin
        for (int g = 0; g < grp[i]; g++) begin
          if (abort) begin drv_valid = '0; return; end
          if (rnd) while ($urandom_range(0, 2) == 0 && !abort) begin
            drv_valid = '0;
            tick();
          end
          case (mode)
            0:       d = {8{8'(p*37 + i*11 + g)}} ^ 64'h0011223344556677;
            1:       d = {$urandom, $urandom};
            default: d = fixed_data[i];
          endcase
          if (mode == 0) ex.data = d;
          else if (mode == 1) for (int l = 0; l < 8; l++)
            ex.data[l*8 +: 8] = model(int'(d[l*8 +: 8]), zpi[i], scl[i], zpo);
          else ex.data = hand_exp[i];
          ex.last = (p == pixn - 1) && (i == last_in) && (g == grp[i] - 1);
          S_Data[i*DW +: DW] = d;
          drv_valid = NI'(1) << i;
          acc = 0;
          n = 0;
          while (!acc && n < 400 && !abort) begin
            @(negedge clk);
            if (S_Ready[i]) begin
              acc = 1;
              exp_q.push_back(ex);
              if (first_acc < 0) first_acc = cyc;
            end
            @(posedge clk);
            #1;
            n++;
          end
          if (!acc && !abort) begin
            n_cmp++;
            n_bad++;
            $display("FAIL s_accept_timeout: input %0d beat not accepted within 400 cycles", i);
            drv_valid = '0;
            return;
          end
        end
      end
    end
    drv_valid = '0;
  endtask

  task automatic wait_done(input int budget, output int dcyc);
    bit ok;
    int n;
    ok = 0; n = 0; dcyc = -1;
    while (!ok && n < budget) begin
      @(negedge clk);
      if (Done) begin ok = 1; dcyc = cyc; end
      n++;
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: Done not seen within %0d cycles", budget);
    end
    tick();
  endtask

  task automatic run_frame(input string tag, input int mode, input bit rnd, input int nbeats);
    int sc, dc;
    apply_cfg();
    reset_trackers();
    start_pulse(sc);
    check({tag, "_busy"}, 64'(Busy), 64'd1);
    drive_frame(mode, rnd);
    wait_done(3000, dc);
    check({tag, "_beats"}, 64'(n_out), 64'(nbeats));
    check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_done_lat"}, 64'(dc - last_acc), 64'd1);
  endtask

  task automatic set_identity(input int g0, input int g1, input int g2, input int pn);
    grp = '{g0, g1, g2};
    zpi = '{0, 0, 0};
    scl = '{32768, 32768, 32768};
    zpo = 0;
    pixn = pn;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int sc, dc;
    rst = 1'b1; Start = 1'b0; drv_valid = '0; bg_valid = '0; S_Data = '0;
    Cfg_Pixel_Num = '0; Cfg_Group_Num = '0; Cfg_ZeroPoint_In = '0; Cfg_Scale = '0; Cfg_ZeroPoint_Out = '0;
    reset_trackers();
    repeat (3) @(posedge clk);
    #1;
    check("reset_mdata", M_Data, 64'd0);
    check("reset_ctrl", 64'({M_Valid, Last_Concat, Busy, Done, S_Ready}), 64'd0);
    rst = 1'b0;
    tick();

    // Test 1 / 6: identity concat, order A,A,B per pixel, latency and throughput
    set_identity(2, 1, 0, 3);
    run_frame("t1", 0, 0, 9);
    check("t1_first_latency", 64'(first_out - first_acc), 64'd2);
    check("t1_throughput", 64'(last_out - first_out), 64'd8);

    // Test 2a: 200/zp100/0x4000/+10 -> 60, low saturation -> 0, high saturation -> 255
    grp = '{1, 1, 1}; pixn = 1; zpo = 10;
    zpi = '{100, 255, 0};
    scl = '{16'h4000, 16'h7FFF, 16'h8000};
    fixed_data = '{{8{8'd200}}, 64'd0, {8{8'd255}}};
    hand_exp   = '{{8{8'd60}}, 64'd0, {8{8'd255}}};
    run_frame("t2a", 2, 0, 3);

    // Test 2b: zp_out=250 unit scale, boundary around 255
    grp = '{1, 0, 0}; pixn = 1; zpo = 250;
    zpi = '{0, 0, 0};
    scl = '{16'h8000, 16'h8000, 16'h8000};
    fixed_data[0] = 64'hFF06050400010203;
    hand_exp[0]   = 64'hFFFFFFFEFAFBFCFD;
    run_frame("t2b", 2, 0, 1);

    // Test 3 + 5a: random valid/ready vs model, Start during RUN ignored
    grp = '{1, 2, 3}; pixn = 4; zpo = 128;
    zpi = '{10, 200, 0};
    scl = '{16'h4000, 16'h9000, 16'h8000};
    apply_cfg();
    reset_trackers();
    rnd_ready = 1;
    start_pulse(sc);
    check("t3_busy", 64'(Busy), 64'd1);
    fork
      drive_frame(1, 1);
      begin
        repeat (8) tick();
        Cfg_Pixel_Num = PIX_W'(1);
        Cfg_Group_Num = {NI{GRP_W'(1)}};
        Start = 1'b1;
        tick();
        Start = 1'b0;
      end
    join
    wait_done(3000, dc);
    rnd_ready = 0;
    check("t3_beats", 64'(n_out), 64'd24);
    check("t3_queue_empty", 64'(exp_q.size()), 64'd0);
    check("t3_done_lat", 64'(dc - last_acc), 64'd1);
    tick();

    // Test 4: groups {0,3,0}, only input 1 consumed even with 0 and 2 valid
    set_identity(0, 3, 0, 2);
    bg_valid = 3'b101;
    watch_other = 1;
    S_Data[0 +: DW] = 64'hDEADBEEFDEADBEEF;
    S_Data[2*DW +: DW] = 64'hCAFEF00DCAFEF00D;
    run_frame("t4", 0, 1, 6);
    check("t4_other_ready", 64'(other_seen), 64'd0);
    bg_valid = '0;
    watch_other = 0;

    // Test 4b: all-zero groups, then pix=0: Done 1 cycle after Start, no M_Valid
    set_identity(0, 0, 0, 3);
    apply_cfg();
    reset_trackers();
    start_pulse(sc);
    wait_done(20, dc);
    check("t4_zero_grp_done", 64'(dc - sc), 64'd1);
    check("t4_zero_grp_mvalid", 64'(mv_seen), 64'd0);
    set_identity(1, 1, 1, 0);
    apply_cfg();
    reset_trackers();
    start_pulse(sc);
    wait_done(20, dc);
    check("t4_zero_pix_done", 64'(dc - sc), 64'd1);
    check("t4_zero_pix_mvalid", 64'(mv_seen), 64'd0);

    // Test 5b: reset mid-frame, then a clean frame
    set_identity(2, 1, 0, 3);
    apply_cfg();
    reset_trackers();
    start_pulse(sc);
    fork
      drive_frame(0, 0);
      begin
        repeat (4) tick();
        abort = 1;
        rst = 1'b1;
        #1;
        check("t5_rst_mdata", M_Data, 64'd0);
        check("t5_rst_ctrl", 64'({M_Valid, Last_Concat, Busy, Done, S_Ready}), 64'd0);
      end
    join
    drv_valid = '0;
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    abort = 0;
    repeat (3) begin
      @(negedge clk);
      check("t5_no_done_after_abort", 64'(Done), 64'd0);
    end
    tick();
    run_frame("t5_clean", 0, 0, 9);
    check("t5_first_latency", 64'(first_out - first_acc), 64'd2);
    check("t5_throughput", 64'(last_out - first_out), 64'd8);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
